// File: rtl/bitsieve_pkg.sv
// Shared types and defaults for the BitSieve selection tree consumer.
// Revision 1.0
`default_nettype none

package bitsieve_pkg;

  localparam int N_SPINS_DEFAULT = 1024;
  localparam int IDX_W_DEFAULT   = 10;
  localparam int IDX_W_MAX       = 10;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    DISPATCH = 1'b1
  } state_t;

  // Index field is sized for the widest legal tree; narrower configs zero-extend.
  typedef struct packed {
    logic [IDX_W_MAX-1:0] index;
    logic                 old_spin;
  } flip_evt_t;

endpackage

`default_nettype wire

// File: rtl/spin_index_decoder.sv
// Candidate index to one-hot toggle mask, with an out-of-range flag.
// Revision 1.0
`default_nettype none

module spin_index_decoder
  import bitsieve_pkg::*;
#(
  parameter int N_SPINS = N_SPINS_DEFAULT,
  parameter int IDX_W   = IDX_W_DEFAULT
) (
  input  logic [IDX_W-1:0]   idx,
  output logic [N_SPINS-1:0] mask,
  output logic               out_of_range
);

  for (genvar i = 0; i < N_SPINS; i++) begin : g_dec
    assign mask[i] = (idx == IDX_W'(i));
  end

  assign out_of_range = (32'(idx) >= N_SPINS);

endmodule

`default_nettype wire

// File: rtl/spin_flip_dispatcher.sv
// Owns the spin register, toggles the selected spin and hands the flip event
// to the field-update engine over a valid/ack handshake. Revision 1.0
`default_nettype none

module spin_flip_dispatcher
  import bitsieve_pkg::*;
#(
  parameter int N_SPINS = N_SPINS_DEFAULT,
  parameter int IDX_W   = IDX_W_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               cand_strobe,
  input  logic [IDX_W-1:0]   cand_index,
  input  logic               cand_any,
  output logic               cand_ready,
  output logic               flip_valid,
  output logic [IDX_W-1:0]   flip_index,
  output logic               flip_old_spin,
  input  logic               flip_ack,
  output logic [N_SPINS-1:0] spin_q,
  output logic               null_event,
  output logic               idx_err,
  output logic [CNT_W-1:0]   flip_count,
  output logic [CNT_W-1:0]   null_count
);

  state_t             state;
  flip_evt_t          evt;
  logic [N_SPINS-1:0] toggle_mask;
  logic               idx_oor;
  logic               old_bit;

  spin_index_decoder #(
    .N_SPINS (N_SPINS),
    .IDX_W   (IDX_W)
  ) u_dec (
    .idx          (cand_index),
    .mask         (toggle_mask),
    .out_of_range (idx_oor)
  );

  // Reduction through the mask avoids indexing past N_SPINS on bad indices.
  assign old_bit       = |(spin_q & toggle_mask);
  assign cand_ready    = (state == IDLE);
  assign flip_index    = evt.index[IDX_W-1:0];
  assign flip_old_spin = evt.old_spin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      spin_q     <= '0;
      evt        <= '0;
      flip_valid <= 1'b0;
      null_event <= 1'b0;
      idx_err    <= 1'b0;
      flip_count <= '0;
      null_count <= '0;
    end else begin
      null_event <= 1'b0;
      if (clr) begin
        state      <= IDLE;
        spin_q     <= '0;
        flip_valid <= 1'b0;
        idx_err    <= 1'b0;
        flip_count <= '0;
        null_count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cand_strobe) begin
              if (!cand_any) begin
                null_event <= 1'b1;
                null_count <= null_count + CNT_W'(null_count != '1);
              end else if (idx_oor) begin
                idx_err <= 1'b1;
              end else begin
                spin_q       <= spin_q ^ toggle_mask;
                evt.index    <= IDX_W_MAX'(cand_index);
                evt.old_spin <= old_bit;
                flip_valid   <= 1'b1;
                state        <= DISPATCH;
              end
            end
          end
          DISPATCH: begin
            if (flip_ack) begin
              flip_valid <= 1'b0;
              flip_count <= flip_count + CNT_W'(flip_count != '1);
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spin_flip_dispatcher.sv
// Bench for spin_flip_dispatcher: directed vector table, saturation and reset
// sequences, then random traffic against an array-based reference model.
`default_nettype none

module tb_spin_flip_dispatcher;

  localparam int NS   = 1000;
  localparam int IW   = 10;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          cand_strobe;
  logic [IW-1:0] cand_index;
  logic          cand_any;
  logic          cand_ready;
  logic          flip_valid;
  logic [IW-1:0] flip_index;
  logic          flip_old_spin;
  logic          flip_ack;
  logic [NS-1:0] spin_q;
  logic          null_event;
  logic          idx_err;
  logic [CW-1:0] flip_count;
  logic [CW-1:0] null_count;

  spin_flip_dispatcher #(.N_SPINS(NS), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .cand_strobe   (cand_strobe),
    .cand_index    (cand_index),
    .cand_any      (cand_any),
    .cand_ready    (cand_ready),
    .flip_valid    (flip_valid),
    .flip_index    (flip_index),
    .flip_old_spin (flip_old_spin),
    .flip_ack      (flip_ack),
    .spin_q        (spin_q),
    .null_event    (null_event),
    .idx_err       (idx_err),
    .flip_count    (flip_count),
    .null_count    (null_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: plain arrays and integers
  bit m_spin [NS];
  bit m_pending;
  int m_idx;
  bit m_old;
  bit m_err;
  bit m_ne;
  int m_fc;
  int m_nc;

  typedef struct {
    bit s; int idx; bit any; bit ack; bit c;
    bit e_valid; int e_idx; bit e_old; bit e_ready;
    int e_fc; int e_nc; bit e_err; bit e_ne;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(string nm, longint act, longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NS; i++) m_spin[i] = 1'b0;
    m_pending = 0; m_idx = 0; m_old = 0; m_err = 0; m_ne = 0; m_fc = 0; m_nc = 0;
  endtask

  task automatic m_step(bit s, int idx, bit any, bit ack, bit c);
    m_ne = 0;
    if (c) begin
      for (int i = 0; i < NS; i++) m_spin[i] = 1'b0;
      m_fc = 0; m_nc = 0; m_err = 0; m_pending = 0;
    end else if (m_pending) begin
      if (ack) begin
        m_pending = 0;
        if (m_fc < CMAX) m_fc++;
      end
    end else if (s) begin
      if (!any) begin
        m_ne = 1;
        if (m_nc < CMAX) m_nc++;
      end else if (idx >= NS) begin
        m_err = 1;
      end else begin
        m_old = m_spin[idx];
        m_spin[idx] = !m_spin[idx];
        m_idx = idx;
        m_pending = 1;
      end
    end
  endtask

  task automatic chk_model(string tag);
    int first_bad;
    first_bad = -1;
    chk({tag, ".ready"}, cand_ready, !m_pending);
    chk({tag, ".valid"}, flip_valid, m_pending);
    if (m_pending) begin
      chk({tag, ".index"}, flip_index, m_idx);
      chk({tag, ".old"}, flip_old_spin, m_old);
    end
    chk({tag, ".null_event"}, null_event, m_ne);
    chk({tag, ".idx_err"}, idx_err, m_err);
    chk({tag, ".flip_count"}, flip_count, m_fc);
    chk({tag, ".null_count"}, null_count, m_nc);
    for (int i = 0; i < NS; i++)
      if (first_bad < 0 && spin_q[i] !== m_spin[i]) first_bad = i;
    nvec++;
    if (first_bad >= 0) begin
      nerr++;
      $display("FAIL %s.spin_q: bit %0d got %0b expected %0b", tag, first_bad,
               spin_q[first_bad], m_spin[first_bad]);
    end
  endtask

  task automatic step(bit s, int idx, bit any, bit ack, bit c, string tag);
    cand_strobe = s;
    cand_index  = IW'(idx);
    cand_any    = any;
    flip_ack    = ack;
    clr         = c;
    m_step(s, idx, any, ack, c);
    @(posedge clk);
    #1;
    chk_model(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 5,    1, 1, 0,  1, 5,   0, 0,  0, 0, 0, 0};
    tbl[1]  = '{0, 0,    0, 1, 0,  0, 5,   0, 1,  1, 0, 0, 0};
    tbl[2]  = '{1, 5,    1, 0, 0,  1, 5,   1, 0,  1, 0, 0, 0};
    tbl[3]  = '{0, 0,    0, 0, 0,  1, 5,   1, 0,  1, 0, 0, 0};
    tbl[4]  = '{1, 7,    1, 0, 0,  1, 5,   1, 0,  1, 0, 0, 0};
    tbl[5]  = '{0, 0,    0, 0, 0,  1, 5,   1, 0,  1, 0, 0, 0};
    tbl[6]  = '{0, 0,    0, 0, 0,  1, 5,   1, 0,  1, 0, 0, 0};
    tbl[7]  = '{0, 0,    0, 1, 0,  0, 5,   1, 1,  2, 0, 0, 0};
    tbl[8]  = '{1, 1023, 0, 0, 0,  0, 0,   0, 1,  2, 1, 0, 1};
    tbl[9]  = '{1, 1023, 0, 0, 0,  0, 0,   0, 1,  2, 2, 0, 1};
    tbl[10] = '{1, 1023, 0, 0, 0,  0, 0,   0, 1,  2, 3, 0, 1};
    tbl[11] = '{0, 0,    0, 1, 0,  0, 0,   0, 1,  2, 3, 0, 0};
    tbl[12] = '{1, 1001, 1, 0, 0,  0, 0,   0, 1,  2, 3, 1, 0};
    tbl[13] = '{0, 0,    0, 0, 0,  0, 0,   0, 1,  2, 3, 1, 0};
    tbl[14] = '{1, 0,    1, 0, 0,  1, 0,   0, 0,  2, 3, 1, 0};
    tbl[15] = '{0, 0,    0, 1, 0,  0, 0,   0, 1,  3, 3, 1, 0};
    tbl[16] = '{1, 999,  1, 0, 0,  1, 999, 0, 0,  3, 3, 1, 0};
    tbl[17] = '{0, 0,    0, 0, 1,  0, 0,   0, 1,  0, 0, 0, 0};

    rst_n = 1'b0; clr = 0; cand_strobe = 0; cand_index = '0; cand_any = 0; flip_ack = 0;
    m_reset();
    #1;
    chk_model("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset.ready_after_release", cand_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      string t;
      t = $sformatf("tbl%0d", i);
      step(tbl[i].s, tbl[i].idx, tbl[i].any, tbl[i].ack, tbl[i].c, t);
      chk({t, ".x_valid"}, flip_valid, tbl[i].e_valid);
      chk({t, ".x_ready"}, cand_ready, tbl[i].e_ready);
      chk({t, ".x_flip_count"}, flip_count, tbl[i].e_fc);
      chk({t, ".x_null_count"}, null_count, tbl[i].e_nc);
      chk({t, ".x_idx_err"}, idx_err, tbl[i].e_err);
      chk({t, ".x_null_event"}, null_event, tbl[i].e_ne);
      if (tbl[i].e_valid) begin
        chk({t, ".x_index"}, flip_index, tbl[i].e_idx);
        chk({t, ".x_old"}, flip_old_spin, tbl[i].e_old);
      end
      if (i == 0) chk({t, ".x_spin5"}, spin_q[5], 1);
      if (i == 7) begin
        chk({t, ".x_spin5"}, spin_q[5], 0);
        chk({t, ".x_spin7"}, spin_q[7], 0);
      end
      if (i == 16) chk({t, ".x_spin999"}, spin_q[999], 1);
      if (i == 17) chk({t, ".x_spin_zero"}, (spin_q == '0), 1);
    end

    // Flip counter saturation
    for (int k = 0; k < 17; k++) begin
      step(1, (k * 37) % NS, 1, 1, 0, "sat.strobe");
      step(0, 0, 0, 1, 0, "sat.ack");
    end
    chk("sat.flip_count", flip_count, CMAX);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      int idx;
      idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NS, 1023))
                                        : int'($urandom_range(0, NS - 1));
      step($urandom_range(0, 1), idx, $urandom_range(0, 4) != 0,
           $urandom_range(0, 1), $urandom_range(0, 39) == 0, "rnd");
    end

    // Async reset in the middle of a dispatch
    step(0, 0, 0, 1, 0, "arst.drain");
    step(1, 10, 1, 0, 0, "arst.load");
    chk("arst.pending", flip_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk_model("arst");
    chk("arst.index_zero", flip_index, 0);
    chk("arst.old_zero", flip_old_spin, 0);
    #1 rst_n = 1'b1;
    step(1, 3, 1, 1, 0, "arst.after");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
